// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - op-class, funct, alu_op and hilo_sel codes plus FSM states for alu_ctrl_muldiv
package alu_ctrl_pkg;

  localparam logic [2:0] CLS_R  = 3'b000;
  localparam logic [2:0] CLS_I  = 3'b001;
  localparam logic [2:0] CLS_J  = 3'b010;
  localparam logic [2:0] CLS_BR = 3'b011;
  localparam logic [2:0] CLS_IF = 3'b100;
  localparam logic [2:0] CLS_ID = 3'b101;
  localparam logic [2:0] CLS_RS = 3'b110;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [2:0] AOP_ADD  = 3'b000;
  localparam logic [2:0] AOP_SUB  = 3'b001;
  localparam logic [2:0] AOP_AND  = 3'b010;
  localparam logic [2:0] AOP_OR   = 3'b011;
  localparam logic [2:0] AOP_SLT  = 3'b100;
  localparam logic [2:0] AOP_CTRL = 3'b111;

  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_HI   = 2'b01;
  localparam logic [1:0] HL_LO   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  function automatic logic [2:0] decode_aluop(input logic [2:0] cls, input logic [5:0] fn);
    logic [2:0] r;
    r = AOP_ADD;
    case (cls)
      CLS_R: begin
        case (fn)
          FN_SUB:  r = AOP_SUB;
          FN_AND:  r = AOP_AND;
          FN_OR:   r = AOP_OR;
          FN_SLT:  r = AOP_SLT;
          default: r = AOP_ADD;
        endcase
      end
      CLS_BR, CLS_RS:               r = AOP_CTRL;
      CLS_I, CLS_J, CLS_IF, CLS_ID: r = AOP_ADD;
      default:                      r = AOP_ADD;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] decode_hilo(input logic [2:0] cls, input logic [5:0] fn);
    logic [1:0] r;
    r = HL_NONE;
    if (cls == CLS_R) begin
      if (fn == FN_MFHI) r = HL_HI;
      else if (fn == FN_MFLO) r = HL_LO;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv_engine.sv
// rtl/alu_muldiv_engine.sv - shift-add multiply / restoring divide datapath with sign fix-up (ALU_CTRL_EARLY_TERM_EN)
module alu_muldiv_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic             step_mul,
  input  logic             step_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             last_mul,
  output logic             last_div,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] prod, mcand, prod_fix;
  logic [WIDTH-1:0]   mq, rem, dvs, mag_a, mag_b, q_fix, r_fix;
  logic [WIDTH:0]     sh, diff;
  logic [CNT_W-1:0]   cnt;
  logic               sa, sb, neg_lo, neg_hi, dz, mode_div;

  assign sa    = is_signed & opa[WIDTH-1];
  assign sb    = is_signed & opb[WIDTH-1];
  assign mag_a = sa ? -opa : opa;
  assign mag_b = sb ? -opb : opb;

  // mq holds the multiplier while multiplying and the dividend/quotient while dividing
  assign sh   = {rem, mq[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};

  assign last_div = (cnt == CNT_W'(WIDTH - 1));
`ifdef ALU_CTRL_EARLY_TERM_EN
  assign last_mul = last_div || (mq[WIDTH-1:1] == '0);
`else
  assign last_mul = last_div;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod     <= '0;
      mcand    <= '0;
      mq       <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz       <= 1'b0;
      mode_div <= 1'b0;
    end else if (start_mul) begin
      prod     <= '0;
      mcand    <= {{WIDTH{1'b0}}, mag_a};
      mq       <= mag_b;
      cnt      <= '0;
      neg_lo   <= sa ^ sb;
      neg_hi   <= sa ^ sb;
      dz       <= 1'b0;
      mode_div <= 1'b0;
    end else if (start_div) begin
      mq       <= mag_a;
      dvs      <= mag_b;
      rem      <= (opb == '0) ? opa : '0;
      cnt      <= '0;
      neg_lo   <= sa ^ sb;
      neg_hi   <= sa;
      dz       <= (opb == '0);
      mode_div <= 1'b1;
    end else if (step_mul) begin
      if (mq[0]) prod <= prod + mcand;
      mcand <= mcand << 1;
      mq    <= mq >> 1;
      cnt   <= cnt + CNT_W'(1);
    end else if (step_div) begin
      rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      mq  <= {mq[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Divide-by-zero bypasses the sign fix-up: rem already holds the raw dividend
  assign prod_fix = neg_lo ? -prod : prod;
  assign q_fix    = neg_lo ? -mq : mq;
  assign r_fix    = neg_hi ? -rem : rem;
  assign res_hi   = mode_div ? (dz ? rem : r_fix) : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = mode_div ? (dz ? {WIDTH{1'b1}} : q_fix) : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - ALU op decode, mul/div sequencer FSM and HI/LO registers (ALU_CTRL_EARLY_TERM_EN)
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         op_class,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         hilo_sel,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_t           state, state_nxt;
  logic             accept, is_mul, is_div, start_mul, start_div;
  logic             last_mul, last_div;
  logic [WIDTH-1:0] eng_hi, eng_lo, hi_q, lo_q;

  assign accept    = req_valid && (state == ST_IDLE);
  assign is_mul    = (op_class == CLS_R) && (funct == FN_MULT || funct == FN_MULTU);
  assign is_div    = (op_class == CLS_R) && (funct == FN_DIV || funct == FN_DIVU);
  assign start_mul = accept && is_mul;
  assign start_div = accept && is_div;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      alu_op   <= '0;
      hilo_sel <= HL_NONE;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_op   <= ALUOP_W'(decode_aluop(op_class, funct));
        hilo_sel <= decode_hilo(op_class, funct);
      end
      if (state == ST_DONE) begin
        hi_q <= eng_hi;
        lo_q <= eng_lo;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (start_mul) state_nxt = ST_MUL;
        else if (start_div) state_nxt = (opb == '0) ? ST_DONE : ST_DIV;
      end
      ST_MUL:  if (last_mul) state_nxt = ST_DONE;
      ST_DIV:  if (last_div) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Fixed-up results are visible during the done pulse and latched as it ends
  assign hi = (state == ST_DONE) ? eng_hi : hi_q;
  assign lo = (state == ST_DONE) ? eng_lo : lo_q;

  alu_muldiv_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_mul (start_mul),
    .start_div (start_div),
    .is_signed (~funct[0]),
    .step_mul  (state == ST_MUL),
    .step_div  (state == ST_DIV),
    .opa       (opa),
    .opb       (opb),
    .last_mul  (last_mul),
    .last_div  (last_div),
    .res_hi    (eng_hi),
    .res_lo    (eng_lo)
  );

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb/tb_alu_ctrl_muldiv.sv - directed vector bench for alu_ctrl_muldiv (ALU_CTRL_EARLY_TERM_EN aware)
module tb_alu_ctrl_muldiv;

`ifdef ALU_CTRL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  localparam int FL = 33;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, busy, done;
  logic [2:0]  op_class, alu_op;
  logic [5:0]  funct;
  logic [31:0] opa, opb, hi, lo;
  logic [1:0]  hilo_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(.WIDTH(32), .ALUOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op_class(op_class), .funct(funct), .opa(opa), .opb(opb),
    .alu_op(alu_op), .hilo_sel(hilo_sel), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [5:0]  fn;
    logic [31:0] a, b;
    logic [2:0]  aop;
    logic [1:0]  hl;
    logic [31:0] ehi, elo;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] c, input logic [5:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [2:0] aop, input logic [1:0] hl,
                              input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    vec_t v;
    v.cls = c; v.fn = f; v.a = a; v.b = b; v.aop = aop; v.hl = hl;
    v.ehi = ehi; v.elo = elo; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; op_class = c; funct = f; opa = a; opb = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; op_class = '0; funct = '0; opa = '0; opb = '0;

    // decode-only vectors
    vecs.push_back(mk(3'b000, 6'b100010, 32'd1, 32'd2, 3'b001, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b000, 6'b100000, 32'd1, 32'd2, 3'b000, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b000, 6'b100100, 32'd1, 32'd2, 3'b010, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b000, 6'b100101, 32'd1, 32'd2, 3'b011, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b000, 6'b101010, 32'd1, 32'd2, 3'b100, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b011, 6'b000000, 32'd1, 32'd2, 3'b111, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b110, 6'b100010, 32'd1, 32'd2, 3'b111, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b001, 6'b100010, 32'd1, 32'd2, 3'b000, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(3'b000, 6'b111111, 32'd1, 32'd2, 3'b000, 2'b00, 32'h0, 32'h0, 0));
    // mul/div vectors, issued back to back
    vecs.push_back(mk(3'b000, 6'b011000, 32'hFFFFFFFD, 32'd7, 3'b000, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFEB, ET ? 4 : FL));
    vecs.push_back(mk(3'b000, 6'b010000, 32'd0, 32'd0, 3'b000, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFEB, 0));
    vecs.push_back(mk(3'b000, 6'b010010, 32'd0, 32'd0, 3'b000, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFEB, 0));
    vecs.push_back(mk(3'b000, 6'b011011, 32'd100, 32'd7, 3'b000, 2'b00, 32'd2, 32'd14, FL));
    vecs.push_back(mk(3'b000, 6'b011010, 32'hFFFFFF9C, 32'd7, 3'b000, 2'b00, 32'hFFFFFFFE, 32'hFFFFFFF2, FL));
    vecs.push_back(mk(3'b000, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 3'b000, 2'b00, 32'h0, 32'h80000000, FL));
    vecs.push_back(mk(3'b000, 6'b011010, 32'd5, 32'd0, 3'b000, 2'b00, 32'd5, 32'hFFFFFFFF, 1));
    vecs.push_back(mk(3'b000, 6'b011001, 32'd5, 32'd3, 3'b000, 2'b00, 32'h0, 32'd15, ET ? 3 : FL));
    vecs.push_back(mk(3'b000, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 2'b00, 32'hFFFFFFFE, 32'h1, FL));
    vecs.push_back(mk(3'b000, 6'b011010, 32'hFFFFFFF9, 32'hFFFFFFFE, 3'b000, 2'b00, 32'hFFFFFFFF, 32'd3, FL));
    vecs.push_back(mk(3'b000, 6'b011010, 32'hFFFFFFFB, 32'd0, 3'b000, 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFF, 1));
    vecs.push_back(mk(3'b000, 6'b011001, 32'd7, 32'd0, 3'b000, 2'b00, 32'h0, 32'h0, ET ? 2 : FL));
    vecs.push_back(mk(3'b000, 6'b011000, 32'd6, 32'hFFFFFFFC, 3'b000, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFE8, ET ? 4 : FL));
    vecs.push_back(mk(3'b000, 6'b011011, 32'hFFFFFFFF, 32'd16, 3'b000, 2'b00, 32'hF, 32'h0FFFFFFF, FL));
    vecs.push_back(mk(3'b000, 6'b010010, 32'd0, 32'd0, 3'b000, 2'b10, 32'hF, 32'h0FFFFFFF, 0));

    repeat (3) @(negedge clk);
    check("reset alu_op", alu_op, 3'b000);
    check("reset hilo_sel", hilo_sel, 2'b00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset req_ready", req_ready, 1'b1);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].cls, vecs[i].fn, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d alu_op", i), alu_op, vecs[i].aop);
      check($sformatf("v%0d hilo_sel", i), hilo_sel, vecs[i].hl);
      if (vecs[i].lat == 0) begin
        check($sformatf("v%0d busy", i), busy, 1'b0);
        check($sformatf("v%0d done", i), done, 1'b0);
      end else begin
        check($sformatf("v%0d req_ready while busy", i), req_ready, 1'b0);
        wait_done(1, lat);
        check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      end
      check($sformatf("v%0d hi", i), hi, vecs[i].ehi);
      check($sformatf("v%0d lo", i), lo, vecs[i].elo);
      if (vecs[i].lat != 0) begin
        @(negedge clk);
        check($sformatf("v%0d done after pulse", i), done, 1'b0);
        check($sformatf("v%0d req_ready after done", i), req_ready, 1'b1);
        check($sformatf("v%0d hi held", i), hi, vecs[i].ehi);
        check($sformatf("v%0d lo held", i), lo, vecs[i].elo);
      end
    end

    // request while busy is dropped, not decoded or queued
    issue(3'b000, 6'b011000, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    issue(3'b011, 6'b000000, 32'd0, 32'd0);
    check("busy-ignore alu_op", alu_op, 3'b000);
    wait_done(5, lat);
    check("busy-ignore mult lo", lo, 32'd6);
    check("busy-ignore mult hi", hi, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("busy-ignore not queued busy", busy, 1'b0);
    check("busy-ignore not queued alu_op", alu_op, 3'b000);

    // reset in the middle of a multiply
    issue(3'b000, 6'b011000, 32'd9, 32'd9);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", busy, 1'b0);
    check("midreset req_ready", req_ready, 1'b1);
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("midreset no done", seen, 1'b0);
    issue(3'b000, 6'b100010, 32'd0, 32'd0);
    check("post-reset sub", alu_op, 3'b001);
    issue(3'b000, 6'b100000, 32'd0, 32'd0);
    check("post-reset add", alu_op, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
